// File: rtl/kb_scan_ctrl.sv
// PS/2 Set-2 keyboard front end: decodes make/break/extended sequences, tracks Shift,
// maps make codes to 7-bit ASCII and queues them in a FWFT FIFO drained by the CPU.
module kb_scan_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  input  logic       KB_read_en,
  input  logic       KB_clear,
  output logic       KB_status,
  output logic [6:0] KB_data,
  output logic       buf_full,
  output logic       kb_overflow
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dec_state_t;

  dec_state_t        dec_state;
  logic              shift;
  logic              stage_valid;
  logic [6:0]        stage_char;
  logic [6:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [7:0]        lk;
  logic              is_full;
  logic              do_pop;
  logic              do_write;

  // Returns {hit, ascii}; letters are looked up as uppercase and folded down when unshifted.
  function automatic logic [7:0] lookup(input logic [7:0] code, input logic up);
    logic       hit;
    logic       letter;
    logic [6:0] ch;
    hit    = 1'b1;
    letter = 1'b1;
    ch     = 7'h00;
    case (code)
      8'h1C: ch = 7'h41;  8'h32: ch = 7'h42;  8'h21: ch = 7'h43;  8'h23: ch = 7'h44;
      8'h24: ch = 7'h45;  8'h2B: ch = 7'h46;  8'h34: ch = 7'h47;  8'h33: ch = 7'h48;
      8'h43: ch = 7'h49;  8'h3B: ch = 7'h4A;  8'h42: ch = 7'h4B;  8'h4B: ch = 7'h4C;
      8'h3A: ch = 7'h4D;  8'h31: ch = 7'h4E;  8'h44: ch = 7'h4F;  8'h4D: ch = 7'h50;
      8'h15: ch = 7'h51;  8'h2D: ch = 7'h52;  8'h1B: ch = 7'h53;  8'h2C: ch = 7'h54;
      8'h3C: ch = 7'h55;  8'h2A: ch = 7'h56;  8'h1D: ch = 7'h57;  8'h22: ch = 7'h58;
      8'h35: ch = 7'h59;  8'h1A: ch = 7'h5A;
      default: begin
        letter = 1'b0;
        case (code)
          8'h45: ch = 7'h30;  8'h16: ch = 7'h31;  8'h1E: ch = 7'h32;  8'h26: ch = 7'h33;
          8'h25: ch = 7'h34;  8'h2E: ch = 7'h35;  8'h36: ch = 7'h36;  8'h3D: ch = 7'h37;
          8'h3E: ch = 7'h38;  8'h46: ch = 7'h39;
          8'h29: ch = 7'h20;  8'h5A: ch = 7'h0D;  8'h66: ch = 7'h08;
          default: hit = 1'b0;
        endcase
      end
    endcase
    if (letter && !up) ch = ch | 7'h20;
    return {hit, ch};
  endfunction

  assign lk = lookup(scan_code, shift);

  // Decoder plus the single pipeline stage holding the translated character.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_state   <= IDLE;
      shift       <= 1'b0;
      stage_valid <= 1'b0;
      stage_char  <= 7'h00;
    end else if (KB_clear) begin
      dec_state   <= IDLE;
      shift       <= 1'b0;
      stage_valid <= 1'b0;
      stage_char  <= 7'h00;
    end else begin
      stage_valid <= 1'b0;
      if (scan_valid) begin
        case (dec_state)
          IDLE: begin
            if (scan_code == 8'hF0) dec_state <= BRK;
            else if (scan_code == 8'hE0) dec_state <= EXT;
            else if (scan_code == 8'h12 || scan_code == 8'h59) shift <= 1'b1;
            else begin
              stage_valid <= lk[7];
              stage_char  <= lk[6:0];
            end
          end
          BRK: begin
            if (scan_code == 8'h12 || scan_code == 8'h59) shift <= 1'b0;
            dec_state <= IDLE;
          end
          EXT:     dec_state <= (scan_code == 8'hF0) ? EXT_BRK : IDLE;
          default: dec_state <= IDLE;
        endcase
      end
    end
  end

  // A write into a full FIFO succeeds only when the head is popped on the same edge.
  assign is_full  = (count == FULL_CNT);
  assign do_pop   = KB_read_en && (count != '0);
  assign do_write = stage_valid && (!is_full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      kb_overflow <= 1'b0;
    end else if (KB_clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      kb_overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({do_write, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (stage_valid && is_full && !do_pop) kb_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && !KB_clear) mem[wr_ptr] <= stage_char;
  end

  assign KB_status = (count != '0);
  assign buf_full  = is_full;
  assign KB_data   = KB_status ? mem[rd_ptr] : 7'h00;

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// Bench for kb_scan_ctrl: scoreboard queue of expected ASCII filled as scan bytes are sent
// and drained through the CPU read handshake.
module tb_kb_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       KB_read_en;
  logic       KB_clear;
  logic       KB_status;
  logic [6:0] KB_data;
  logic       buf_full;
  logic       kb_overflow;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  logic [7:0] digit_code [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                  8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  kb_scan_ctrl #(.ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .scan_code(scan_code), .scan_valid(scan_valid),
    .KB_read_en(KB_read_en), .KB_clear(KB_clear), .KB_status(KB_status),
    .KB_data(KB_data), .buf_full(buf_full), .kb_overflow(kb_overflow)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    scan_code  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0b want %0b", name, got, want);
    end
  endtask

  task automatic drain(input string name);
    int guard;
    logic [6:0] e;
    guard = 0;
    while (KB_status === 1'b1 && guard < 64) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s extra char got %02h want none", name, KB_data);
      end else begin
        e = exp_q.pop_front();
        if (KB_data !== e) begin
          errors++;
          $display("FAIL %s data got %02h want %02h", name, KB_data, e);
        end
      end
      KB_read_en = 1'b1;
      @(negedge clk);
      KB_read_en = 1'b0;
      guard++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing got %0d left want 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (KB_data !== 7'h00) begin
      errors++;
      $display("FAIL %s empty_data got %02h want 00", name, KB_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scan_code = 8'h00; scan_valid = 1'b0; KB_read_en = 1'b0; KB_clear = 1'b0;
    repeat (3) @(negedge clk);
    check_bit("reset_status", KB_status, 1'b0);
    check_bit("reset_full", buf_full, 1'b0);
    check_bit("reset_ovf", kb_overflow, 1'b0);
    checks++;
    if (KB_data !== 7'h00) begin
      errors++;
      $display("FAIL reset_data got %02h want 00", KB_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    KB_read_en = 1'b1;
    @(negedge clk);
    KB_read_en = 1'b0;
    check_bit("empty_pop_status", KB_status, 1'b0);
    send_byte(8'h1C);
    exp_q.push_back(7'h61);
    check_bit("latency_n_status", KB_status, 1'b0);
    @(negedge clk);
    check_bit("latency_n1_status", KB_status, 1'b1);
    drain("single");
  endtask

  task automatic test_shift();
    logic [7:0] seq [7] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    foreach (seq[i]) send_byte(seq[i]);
    exp_q.push_back(7'h41);
    exp_q.push_back(7'h61);
    settle();
    drain("shift");
  endtask

  task automatic test_ext();
    logic [7:0] seq [7] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h0E, 8'h16};
    foreach (seq[i]) send_byte(seq[i]);
    exp_q.push_back(7'h31);
    send_byte(8'h32);
    exp_q.push_back(7'h62);
    settle();
    drain("ext");
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      k = $urandom_range(0, 9);
      scan_code  = digit_code[k];
      scan_valid = 1'b1;
      exp_q.push_back(7'h30 + 7'(k));
      @(negedge clk);
    end
    scan_valid = 1'b0;
    settle();
    drain("back_to_back");
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h15);
      exp_q.push_back(7'h71);
    end
    settle();
    check_bit("full_16", buf_full, 1'b1);
    check_bit("ovf_16", kb_overflow, 1'b0);
    send_byte(8'h15);
    settle();
    check_bit("ovf_17", kb_overflow, 1'b1);
    check_bit("full_17", buf_full, 1'b1);
    drain("full_readback");
    check_bit("ovf_sticky", kb_overflow, 1'b1);
    @(negedge clk);
    KB_clear = 1'b1;
    @(negedge clk);
    KB_clear = 1'b0;
    check_bit("ovf_cleared", kb_overflow, 1'b0);

    for (int i = 0; i < 16; i++) begin
      send_byte(8'h15);
      exp_q.push_back(7'h71);
    end
    settle();
    @(negedge clk);
    scan_code  = 8'h15;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    KB_read_en = 1'b1;
    checks++;
    if (KB_data !== exp_q[0]) begin
      errors++;
      $display("FAIL aligned_head got %02h want %02h", KB_data, exp_q[0]);
    end
    void'(exp_q.pop_front());
    exp_q.push_back(7'h71);
    @(negedge clk);
    KB_read_en = 1'b0;
    check_bit("aligned_full", buf_full, 1'b1);
    check_bit("aligned_ovf", kb_overflow, 1'b0);
    drain("aligned_readback");
  endtask

  task automatic test_clear();
    send_byte(8'h1C);
    send_byte(8'h32);
    send_byte(8'h21);
    settle();
    @(negedge clk);
    scan_code  = 8'h23;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_code  = 8'h24;
    KB_clear   = 1'b1;
    KB_read_en = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    KB_clear   = 1'b0;
    KB_read_en = 1'b0;
    check_bit("clear_status", KB_status, 1'b0);
    check_bit("clear_full", buf_full, 1'b0);
    check_bit("clear_ovf", kb_overflow, 1'b0);
    @(negedge clk);
    check_bit("clear_pending_dropped", KB_status, 1'b0);
    exp_q.delete();
    send_byte(8'h1C);
    exp_q.push_back(7'h61);
    settle();
    drain("after_clear");
  endtask

  task automatic test_reset_mid();
    send_byte(8'h12);
    send_byte(8'hF0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_bit("mid_reset_status", KB_status, 1'b0);
    send_byte(8'h1C);
    exp_q.push_back(7'h61);
    settle();
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single();
    test_shift();
    test_ext();
    test_back_to_back();
    test_full();
    test_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
